// File: rtl/uart_autobaud.sv
// uart_autobaud
//   Automatic baud-rate detector for the AXI-stream UART. It waits for a 0x55
//   sync character (8N1, LSB first) on the raw rxd line and measures the span
//   from the first to the fifth falling edge, which is 8 bit times. From that
//   span it derives the prescale value the UART rx/tx consume, where one bit
//   period is prescale*8 clk cycles. The locked value is held until the next
//   arm pulse.
//
//   Build option: define UART_AUTOBAUD_GLITCH_FILTER_EN to place a 3-tap
//   majority filter after the input synchronizer. The filter suppresses
//   single-cycle glitches and adds 2 cycles to every latency. Measured
//   intervals are not affected. The default build has no filter.
//
// Ports:
//   clk             clock
//   rst             synchronous active-high reset
//   rxd             raw serial line, asynchronous, idle high
//   arm             single-cycle pulse; starts or restarts detection
//   prescale        last locked prescale value (registered)
//   prescale_valid  high while prescale holds a lock taken since the last arm
//   busy            high while detection is in progress
//   done            single-cycle pulse on a successful lock
//   error           single-cycle pulse on a failed detection
module uart_autobaud #(
  parameter int PRESCALE_WIDTH = 16,
  parameter int CNT_WIDTH      = PRESCALE_WIDTH + 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rxd,
  input  logic                      arm,
  output logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      prescale_valid,
  output logic                      busy,
  output logic                      done,
  output logic                      error
);

  // Width of the rounded span: (CNT_WIDTH+1)-bit sum shifted right by 6.
  localparam int RES_WIDTH = CNT_WIDTH - 5;
  localparam logic [RES_WIDTH-1:0] PRESCALE_MAX = RES_WIDTH'({PRESCALE_WIDTH{1'b1}});

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE,
    STOP_CHK
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic rxd_meta_q;
  logic rxd_sync_q;
  logic rxd_s;

  // NOTE: every clocked register uses non-blocking assignment so that all
  // flops sample their inputs before any of them update; a blocking chain here
  // would collapse the two synchronizer stages into one.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
    end
  end

`ifdef UART_AUTOBAUD_GLITCH_FILTER_EN
  // The majority of the synchronizer output and its two delayed copies only
  // follows a level that has persisted for two cycles; registering the vote
  // makes the total added delay exactly 2 cycles for every edge.
  logic [1:0] tap_q;
  logic       rxd_filt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tap_q      <= 2'b11;
      rxd_filt_q <= 1'b1;
    end else begin
      tap_q      <= {tap_q[0], rxd_sync_q};
      rxd_filt_q <= (rxd_sync_q & tap_q[0]) | (rxd_sync_q & tap_q[1]) |
                    (tap_q[0] & tap_q[1]);
    end
  end

  assign rxd_s = rxd_filt_q;
`else
  assign rxd_s = rxd_sync_q;
`endif

  // ---------------------------------------------------------------------------
  // State and measurement registers
  // ---------------------------------------------------------------------------
  state_t                    state_q,       state_d;
  logic                      rxd_prev_q;
  logic [CNT_WIDTH-1:0]      cnt_total_q,   cnt_total_d;
  logic [CNT_WIDTH-1:0]      cnt_int_q,     cnt_int_d;
  logic [CNT_WIDTH-1:0]      rise_off_q,    rise_off_d;
  logic [CNT_WIDTH-1:0]      i1_q,          i1_d;
  logic [CNT_WIDTH-1:0]      stop_cnt_q,    stop_cnt_d;
  logic [2:0]                edge_idx_q,    edge_idx_d;
  logic                      rise_seen_q,   rise_seen_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q,    prescale_d;
  logic                      valid_q,       valid_d;
  logic                      done_q,        done_d;
  logic                      error_q,       error_d;

  logic fall;
  logic rise;

  assign fall = rxd_prev_q & ~rxd_s;
  assign rise = ~rxd_prev_q & rxd_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rxd_prev_q  <= 1'b1;
      cnt_total_q <= '0;
      cnt_int_q   <= '0;
      rise_off_q  <= '0;
      i1_q        <= '0;
      stop_cnt_q  <= '0;
      edge_idx_q  <= '0;
      rise_seen_q <= 1'b0;
      prescale_q  <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rxd_prev_q  <= rxd_s;
      cnt_total_q <= cnt_total_d;
      cnt_int_q   <= cnt_int_d;
      rise_off_q  <= rise_off_d;
      i1_q        <= i1_d;
      stop_cnt_q  <= stop_cnt_d;
      edge_idx_q  <= edge_idx_d;
      rise_seen_q <= rise_seen_d;
      prescale_q  <= prescale_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Interval arithmetic
  // ---------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] interval;
  logic [CNT_WIDTH-1:0] i1_ref;
  logic [CNT_WIDTH-1:0] int_diff;
  logic [CNT_WIDTH-1:0] high_w;
  logic [CNT_WIDTH-1:0] stop_win;
  logic [CNT_WIDTH-1:0] stop_elapsed;
  logic [CNT_WIDTH:0]   interval_x;
  logic [CNT_WIDTH:0]   twice_h;
  logic [CNT_WIDTH:0]   h_diff;
  logic [CNT_WIDTH:0]   total_x;
  logic [RES_WIDTH-1:0] rounded;
  logic                 int_ok;
  logic                 h_ok;
  logic                 res_ok;
  logic                 timeout;

  // cnt_int holds (cycles since the interval's opening fall) - 1, so the
  // closing fall sees an interval of cnt_int+1. The timeout check has priority,
  // so this sum never wraps when it is used.
  assign interval     = cnt_int_q + CNT_WIDTH'(1);
  // The interval closed by the 2nd falling edge becomes the reference I1.
  assign i1_ref       = (edge_idx_q == 3'd1) ? interval : i1_q;
  assign int_diff     = (interval >= i1_ref) ? interval - i1_ref : i1_ref - interval;
  assign int_ok       = int_diff <= (i1_ref >> 3);
  assign high_w       = interval - rise_off_q;
  assign interval_x   = {1'b0, interval};
  assign twice_h      = {high_w, 1'b0};
  assign h_diff       = (twice_h >= interval_x) ? twice_h - interval_x
                                                : interval_x - twice_h;
  assign h_ok         = h_diff <= (interval_x >> 2);
  assign stop_win     = (i1_q >> 1) + (i1_q >> 3);
  assign stop_elapsed = stop_cnt_q + CNT_WIDTH'(1);
  assign total_x      = {1'b0, cnt_total_q};
  // Span / 64 rounded to nearest (ties round up).
  assign rounded      = RES_WIDTH'((total_x + (CNT_WIDTH+1)'(32)) >> 6);
  assign res_ok       = (rounded != '0) && (rounded <= PRESCALE_MAX);
  assign timeout      = (&cnt_int_q) | (&cnt_total_q);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written below is given a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_total_d = cnt_total_q;
    cnt_int_d   = cnt_int_q;
    rise_off_d  = rise_off_q;
    i1_d        = i1_q;
    stop_cnt_d  = stop_cnt_q;
    edge_idx_d  = edge_idx_q;
    rise_seen_d = rise_seen_q;
    prescale_d  = prescale_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    error_d     = 1'b0;

    if (arm) begin
      // Re-arming aborts any measurement silently; prescale keeps its old value.
      state_d = ARMED;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;

        ARMED: begin
          if (fall) begin
            cnt_total_d = '0;
            cnt_int_d   = '0;
            edge_idx_d  = 3'd1;
            rise_seen_d = 1'b0;
            state_d     = MEASURE;
          end
        end

        MEASURE: begin
          if (timeout) begin
            error_d = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_total_d = cnt_total_q + CNT_WIDTH'(1);
            cnt_int_d   = cnt_int_q + CNT_WIDTH'(1);
            if (rise) begin
              rise_off_d  = cnt_int_q;
              rise_seen_d = 1'b1;
            end else if (fall) begin
              if (!rise_seen_q || !int_ok || !h_ok) begin
                error_d = 1'b1;
                state_d = IDLE;
              end else begin
                if (edge_idx_q == 3'd1) begin
                  i1_d = interval;
                end
                cnt_int_d   = '0;
                rise_seen_d = 1'b0;
                edge_idx_d  = edge_idx_q + 3'd1;
                // The 5th falling edge: cnt_total_d now equals the full
                // 8-bit-time span and stays frozen through STOP_CHK.
                if (edge_idx_q == 3'd4) begin
                  stop_cnt_d = '0;
                  state_d    = STOP_CHK;
                end
              end
            end
          end
        end

        STOP_CHK: begin
          if (rise) begin
            if (res_ok) begin
              prescale_d = rounded[PRESCALE_WIDTH-1:0];
              valid_d    = 1'b1;
              done_d     = 1'b1;
            end else begin
              error_d = 1'b1;
            end
            state_d = IDLE;
          end else if (stop_elapsed >= stop_win) begin
            error_d = 1'b1;
            state_d = IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + CNT_WIDTH'(1);
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign prescale       = prescale_q;
  assign prescale_valid = valid_q;
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign error          = error_q;

endmodule
